// File: rtl/riscv_pkg.sv
// Shared definitions for the fetch front end: data width, reset vector,
// canonical NOP encoding and the fetch FSM state encoding.
package riscv_pkg;

  localparam int          XLEN     = 32;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] NOP      = 32'h0000_0013;

  typedef logic [0:0] fetch_state_t;
  localparam fetch_state_t IDLE = 1'b0;
  localparam fetch_state_t RUN  = 1'b1;

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous FIFO of {instr, pc} pairs with a combinational head read
// and a clear that overrides push and pop.
module fetch_fifo #(
  parameter int WIDTH1     = 32,
  parameter int FIFO_DEPTH = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        push,
  input  logic                        pop,
  input  logic                        clear,
  input  logic [WIDTH1-1:0]           wr_instr,
  input  logic [WIDTH1-1:0]           wr_pc,
  output logic [$clog2(FIFO_DEPTH):0] count,
  output logic [WIDTH1-1:0]           rd_instr,
  output logic [WIDTH1-1:0]           rd_pc
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [WIDTH1-1:0] instr_mem [FIFO_DEPTH];
  logic [WIDTH1-1:0] pc_mem    [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is only observed while count != 0.
  always_ff @(posedge clk) begin
    if (push && !clear) begin
      instr_mem[wr_ptr] <= wr_instr;
      pc_mem[wr_ptr]    <= wr_pc;
    end
  end

  assign rd_instr = instr_mem[rd_ptr];
  assign rd_pc    = pc_mem[rd_ptr];

endmodule

// File: rtl/instruction_fetch.sv
// PC generator and fetch buffer feeding decode over valid/ready; handles
// branch redirects with a full flush and flags misaligned targets.
//
// state | meaning
// IDLE  | fetch stalled, buffer and fetch_pc retained
// RUN   | one instruction pushed per cycle while buffer has room
module instruction_fetch
  import riscv_pkg::*;
#(
  parameter int                WIDTH1     = XLEN,
  parameter logic [WIDTH1-1:0] RESET_PC   = riscv_pkg::RESET_PC,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_en,
  output logic [WIDTH1-1:0] imem_addr,
  input  logic [WIDTH1-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [WIDTH1-1:0] redirect_pc,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [WIDTH1-1:0] out_instr,
  output logic [WIDTH1-1:0] out_pc,
  output logic              misalign_err
);

  localparam int            CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  fetch_state_t      state;
  logic [WIDTH1-1:0] fetch_pc;
  logic [CW-1:0]     count;
  logic [WIDTH1-1:0] head_instr;
  logic [WIDTH1-1:0] head_pc;
  logic [WIDTH1-1:0] hold_instr;
  logic [WIDTH1-1:0] hold_pc;
  logic              push;
  logic              pop;

  assign out_valid = (count != '0);
  assign pop       = out_valid & out_ready;
  assign push      = (state == RUN) & ~redirect_valid & ((count < DEPTH_C) | pop);
  assign imem_addr = fetch_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      fetch_pc     <= RESET_PC;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        IDLE:    if (fetch_en)  state <= RUN;
        RUN:     if (!fetch_en) state <= IDLE;
        default: state <= IDLE;
      endcase
      if (redirect_valid) begin
        fetch_pc <= {redirect_pc[WIDTH1-1:2], 2'b00};
        if (redirect_pc[1:0] != 2'b00) misalign_err <= 1'b1;
      end else if (push) begin
        fetch_pc <= fetch_pc + WIDTH1'(4);
      end
    end
  end

  // Last head shown to decode, replayed on the outputs while the buffer is empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_instr <= '0;
      hold_pc    <= '0;
    end else if (out_valid) begin
      hold_instr <= head_instr;
      hold_pc    <= head_pc;
    end
  end

  assign out_instr = out_valid ? head_instr : hold_instr;
  assign out_pc    = out_valid ? head_pc    : hold_pc;

  fetch_fifo #(
    .WIDTH1     (WIDTH1),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .push     (push),
    .pop      (pop & ~redirect_valid),
    .clear    (redirect_valid),
    .wr_instr (imem_rdata),
    .wr_pc    (fetch_pc),
    .count    (count),
    .rd_instr (head_instr),
    .rd_pc    (head_pc)
  );

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: two instances, one with the default
// reset vector and one starting at 0xFFFFFFFC to exercise PC wrap.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        fetch_en, out_ready, redirect_valid;
  logic [31:0] redirect_pc;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc;
  logic        out_valid, misalign_err;

  logic        fetch_en2, out_ready2, redirect_valid2;
  logic [31:0] redirect_pc2;
  logic [31:0] imem_addr2, imem_rdata2, out_instr2, out_pc2;
  logic        out_valid2, misalign_err2;

  logic [31:0] mem [0:63];

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  always_comb imem_rdata  = mem[imem_addr[7:2]];
  always_comb imem_rdata2 = mem[imem_addr2[7:2]];

  instruction_fetch #(.WIDTH1(32), .RESET_PC(32'h0000_0000), .FIFO_DEPTH(2)) dut (
    .clk(clk), .reset(reset), .fetch_en(fetch_en), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr),
    .out_pc(out_pc), .misalign_err(misalign_err)
  );

  instruction_fetch #(.WIDTH1(32), .RESET_PC(32'hFFFF_FFFC), .FIFO_DEPTH(2)) dut2 (
    .clk(clk), .reset(reset), .fetch_en(fetch_en2), .imem_addr(imem_addr2),
    .imem_rdata(imem_rdata2), .redirect_valid(redirect_valid2), .redirect_pc(redirect_pc2),
    .out_valid(out_valid2), .out_ready(out_ready2), .out_instr(out_instr2),
    .out_pc(out_pc2), .misalign_err(misalign_err2)
  );

  // Memory word at word index i is 0xA5000000 + i.
  function automatic logic [31:0] w(input int idx);
    return 32'hA500_0000 + 32'(idx);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = w(i);
    reset = 1'b1; fetch_en = 1'b0; out_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    fetch_en2 = 1'b0; out_ready2 = 1'b0; redirect_valid2 = 1'b0; redirect_pc2 = '0;
    #2;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_instr", out_instr, 32'd0);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_misalign", {31'd0, misalign_err}, 32'd0);
    chk("rst_addr", imem_addr, 32'd0);
    chk("rst_addr2", imem_addr2, 32'hFFFF_FFFC);

    // 1: streaming with decode always ready
    #10;
    reset = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
    tick(); chk("t1_lat_valid", {31'd0, out_valid}, 32'd0);
    tick(); chk("t1_valid", {31'd0, out_valid}, 32'd1);
    chk("t1_pc0", out_pc, 32'h0); chk("t1_w0", out_instr, w(0));
    tick(); chk("t1_pc4", out_pc, 32'h4); chk("t1_w1", out_instr, w(1));
    tick(); chk("t1_pc8", out_pc, 32'h8); chk("t1_w2", out_instr, w(2));
    tick(); chk("t1_pcC", out_pc, 32'hC); chk("t1_w3", out_instr, w(3));

    // 2: backpressure fills buffer, then drains without gap
    reset = 1'b1; #1;
    chk("t2_rst_valid", {31'd0, out_valid}, 32'd0);
    reset = 1'b0; out_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t2_full_valid", {31'd0, out_valid}, 32'd1);
    chk("t2_full_pc", out_pc, 32'h0);
    chk("t2_addr_held", imem_addr, 32'h8);
    out_ready = 1'b1;
    tick(); chk("t2_pc4", out_pc, 32'h4);
    tick(); chk("t2_pc8", out_pc, 32'h8); chk("t2_w2", out_instr, w(2));
    tick(); chk("t2_pcC", out_pc, 32'hC);

    // 3: redirect while full
    reset = 1'b1; #1; reset = 1'b0; out_ready = 1'b0;
    tick(); tick(); tick(); tick();
    chk("t3_full_pc", out_pc, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h38;
    tick();
    chk("t3_flush_valid", {31'd0, out_valid}, 32'd0);
    chk("t3_addr", imem_addr, 32'h38);
    redirect_valid = 1'b0; out_ready = 1'b1;
    tick(); chk("t3_pc38", out_pc, 32'h38); chk("t3_w38", out_instr, w(14));
    tick(); chk("t3_pc3C", out_pc, 32'h3C); chk("t3_w3C", out_instr, w(15));
    chk("t3_no_misalign", {31'd0, misalign_err}, 32'd0);

    // 4: misaligned redirect is sticky
    redirect_valid = 1'b1; redirect_pc = 32'h3A;
    tick();
    chk("t4_misalign", {31'd0, misalign_err}, 32'd1);
    chk("t4_addr", imem_addr, 32'h38);
    chk("t4_flush_valid", {31'd0, out_valid}, 32'd0);
    redirect_valid = 1'b0;
    tick(); chk("t4_pc38", out_pc, 32'h38);
    redirect_valid = 1'b1; redirect_pc = 32'h10;
    tick(); chk("t4_sticky", {31'd0, misalign_err}, 32'd1);
    redirect_valid = 1'b0;
    tick(); chk("t4_pc10", out_pc, 32'h10);

    // 5: asynchronous reset with buffer occupied
    out_ready = 1'b0;
    tick(); tick();
    chk("t5_pre_valid", {31'd0, out_valid}, 32'd1);
    reset = 1'b1; #1;
    chk("t5_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_pc", out_pc, 32'd0);
    chk("t5_instr", out_instr, 32'd0);
    chk("t5_addr", imem_addr, 32'd0);
    chk("t5_misalign", {31'd0, misalign_err}, 32'd0);
    reset = 1'b0; out_ready = 1'b1;
    tick(); tick();
    chk("t5_first_pc", out_pc, 32'h0); chk("t5_first_w", out_instr, w(0));

    // 6: PC wrap and fetch_en drop with buffered entries draining
    reset = 1'b1; #1;
    chk("t6_rst_pc2", out_pc2, 32'd0);
    reset = 1'b0; fetch_en = 1'b0; fetch_en2 = 1'b1; out_ready2 = 1'b1;
    tick(); chk("t6_lat_valid2", {31'd0, out_valid2}, 32'd0);
    tick(); chk("t6_pcFFC", out_pc2, 32'hFFFF_FFFC); chk("t6_wFFC", out_instr2, w(63));
    tick(); chk("t6_pc0", out_pc2, 32'h0); chk("t6_w0", out_instr2, w(0));
    out_ready2 = 1'b0;
    tick();
    fetch_en2 = 1'b0;
    tick();
    chk("t6_addr_stop", imem_addr2, 32'h8);
    chk("t6_head_pc", out_pc2, 32'h0);
    out_ready2 = 1'b1;
    tick(); chk("t6_drain_pc4", out_pc2, 32'h4); chk("t6_drain_valid", {31'd0, out_valid2}, 32'd1);
    tick(); chk("t6_empty", {31'd0, out_valid2}, 32'd0);
    chk("t6_hold_pc", out_pc2, 32'h4); chk("t6_addr_final", imem_addr2, 32'h8);
    chk("t6_misalign2", {31'd0, misalign_err2}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
